dataslot_cmd_sequencer: RTL and testbench

//  Core-side initiator for bridge target dataslot commands (read/write) toward core_bridge_cmd.

---
 rtl/dataslot_cmd_sequencer.sv | 167 ++++++++++++++++
 tb/tb_dataslot_cmd_sequencer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dataslot_cmd_sequencer.sv
// Core-side initiator for bridge target dataslot read/write commands: enforces an inter-command
// gap, retries on ack timeout, times out a missing done, and holds a response for the core.
module dataslot_cmd_sequencer #(
    parameter int unsigned MIN_GAP      = 16,
    parameter int unsigned ACK_TIMEOUT  = 1048576,
    parameter int unsigned DONE_TIMEOUT = 67108864,
    parameter int unsigned MAX_RETRIES  = 2
) (
    input  logic        clk_74a,
    input  logic        reset,
    input  logic        enable,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_id,
    input  logic [31:0] req_slotoffset,
    input  logic [31:0] req_bridgeaddr,
    input  logic [31:0] req_length,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [2:0]  rsp_err,
    output logic        rsp_timeout,
    output logic        busy,
    output logic        target_dataslot_read,
    output logic        target_dataslot_write,
    output logic [15:0] target_dataslot_id,
    output logic [31:0] target_dataslot_slotoffset,
    output logic [31:0] target_dataslot_bridgeaddr,
    output logic [31:0] target_dataslot_length,
    input  logic        target_dataslot_ack,
    input  logic        target_dataslot_done,
    input  logic [2:0]  target_dataslot_err
);

    localparam int unsigned MaxAckDone = (ACK_TIMEOUT > DONE_TIMEOUT) ? ACK_TIMEOUT : DONE_TIMEOUT;
    localparam int unsigned CntMax     = (MaxAckDone > MIN_GAP) ? MaxAckDone : MIN_GAP;
    localparam int unsigned CntW       = $clog2(CntMax + 1);
    localparam int unsigned RetW       = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    // A zero gap still spends one cycle in GAP so every strobe is preceded by an idle cycle.
    localparam logic [CntW-1:0] GapLast  = CntW'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);
    localparam logic [CntW-1:0] AckLast  = CntW'(ACK_TIMEOUT - 1);
    localparam logic [CntW-1:0] DoneLast = CntW'(DONE_TIMEOUT - 1);
    localparam logic [RetW-1:0] RetMax   = RetW'(MAX_RETRIES);

    typedef enum logic [2:0] {StIdle, StGap, StIssue, StWaitDone, StResp} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [RetW-1:0] retry_q, retry_d;
    logic [2:0]      err_q, err_d;
    logic            tmo_q, tmo_d;
    logic            write_q;
    logic            accept;

    assign req_ready             = (state_q == StIdle) && enable;
    assign accept                = req_valid && req_ready;
    assign busy                  = (state_q != StIdle);
    assign rsp_valid             = (state_q == StResp);
    assign rsp_err               = err_q;
    assign rsp_timeout           = tmo_q;
    assign target_dataslot_read  = (state_q == StIssue) && !write_q;
    assign target_dataslot_write = (state_q == StIssue) && write_q;

    always_ff @(posedge clk_74a) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            retry_q <= '0;
            err_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    // Command parameters only move on accept so the bridge sees them stable across retries.
    always_ff @(posedge clk_74a) begin
        if (reset) begin
            write_q                    <= 1'b0;
            target_dataslot_id         <= '0;
            target_dataslot_slotoffset <= '0;
            target_dataslot_bridgeaddr <= '0;
            target_dataslot_length     <= '0;
        end else if (accept) begin
            write_q                    <= req_write;
            target_dataslot_id         <= req_id;
            target_dataslot_slotoffset <= req_slotoffset;
            target_dataslot_bridgeaddr <= req_bridgeaddr;
            target_dataslot_length     <= req_length;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntW'(1);
        retry_d = retry_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        case (state_q)
            StIdle: begin
                cnt_d   = '0;
                retry_d = '0;
                if (accept) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    state_d = StIssue;
                    cnt_d   = '0;
                end
            end
            StIssue: begin
                if (target_dataslot_ack) begin
                    cnt_d = '0;
                    if (target_dataslot_done) begin
                        state_d = StResp;
                        err_d   = target_dataslot_err;
                        tmo_d   = 1'b0;
                    end else begin
                        state_d = StWaitDone;
                    end
                end else if (cnt_q == AckLast) begin
                    cnt_d = '0;
                    if (retry_q < RetMax) begin
                        retry_d = retry_q + RetW'(1);
                        state_d = StGap;
                    end else begin
                        state_d = StResp;
                        err_d   = '0;
                        tmo_d   = 1'b1;
                    end
                end
            end
            StWaitDone: begin
                if (target_dataslot_done) begin
                    state_d = StResp;
                    cnt_d   = '0;
                    err_d   = target_dataslot_err;
                    tmo_d   = 1'b0;
                end else if (cnt_q == DoneLast) begin
                    state_d = StResp;
                    cnt_d   = '0;
                    err_d   = '0;
                    tmo_d   = 1'b1;
                end
            end
            StResp: begin
                cnt_d = '0;
                if (rsp_ready) begin
                    state_d = StIdle;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_dataslot_cmd_sequencer.sv
// Bench for dataslot_cmd_sequencer: directed scenarios and randomized transactions, each checked
// cycle by cycle against a timeline computed arithmetically from the command protocol rules.
module tb_dataslot_cmd_sequencer;

    localparam int MIN_GAP      = 16;
    localparam int ACK_TIMEOUT  = 8;
    localparam int DONE_TIMEOUT = 32;
    localparam int MAX_RETRIES  = 2;
    localparam int NUM_ATT      = MAX_RETRIES + 1;

    logic        clk_74a = 1'b0;
    logic        reset;
    logic        enable;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_id;
    logic [31:0] req_slotoffset;
    logic [31:0] req_bridgeaddr;
    logic [31:0] req_length;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_err;
    logic        rsp_timeout;
    logic        busy;
    logic        target_dataslot_read;
    logic        target_dataslot_write;
    logic [15:0] target_dataslot_id;
    logic [31:0] target_dataslot_slotoffset;
    logic [31:0] target_dataslot_bridgeaddr;
    logic [31:0] target_dataslot_length;
    logic        target_dataslot_ack;
    logic        target_dataslot_done;
    logic [2:0]  target_dataslot_err;

    int checks = 0;
    int errors = 0;

    always #5 clk_74a = ~clk_74a;

    dataslot_cmd_sequencer #(
        .MIN_GAP      (MIN_GAP),
        .ACK_TIMEOUT  (ACK_TIMEOUT),
        .DONE_TIMEOUT (DONE_TIMEOUT),
        .MAX_RETRIES  (MAX_RETRIES)
    ) dut (
        .clk_74a                    (clk_74a),
        .reset                      (reset),
        .enable                     (enable),
        .req_valid                  (req_valid),
        .req_ready                  (req_ready),
        .req_write                  (req_write),
        .req_id                     (req_id),
        .req_slotoffset             (req_slotoffset),
        .req_bridgeaddr             (req_bridgeaddr),
        .req_length                 (req_length),
        .rsp_valid                  (rsp_valid),
        .rsp_ready                  (rsp_ready),
        .rsp_err                    (rsp_err),
        .rsp_timeout                (rsp_timeout),
        .busy                       (busy),
        .target_dataslot_read       (target_dataslot_read),
        .target_dataslot_write      (target_dataslot_write),
        .target_dataslot_id         (target_dataslot_id),
        .target_dataslot_slotoffset (target_dataslot_slotoffset),
        .target_dataslot_bridgeaddr (target_dataslot_bridgeaddr),
        .target_dataslot_length     (target_dataslot_length),
        .target_dataslot_ack        (target_dataslot_ack),
        .target_dataslot_done       (target_dataslot_done),
        .target_dataslot_err        (target_dataslot_err)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, got running required finished");
        $fatal(1, "watchdog");
    end

    // Cycle 0 is the accept cycle. Attempt a strobes from rise[a]; an ack at offset k ends it.
    // done_d: 0 = done with ack, 1..DONE_TIMEOUT = cycles after ack, other = never.
    task automatic run_txn(input logic wr, input logic [15:0] id, input logic [31:0] off,
                           input logic [31:0] addr, input logic [31:0] len,
                           input int ack0, input int ack1, input int ack2, input int done_d,
                           input logic [2:0] err, input int rdelay,
                           output int obs_rise, output int obs_resp);
        int         ack_off[NUM_ATT];
        int         rise[NUM_ATT];
        int         acked, last_att, ack_t, done_t, resp_t, t_hs, sel;
        logic [2:0] exp_err;
        logic       exp_tmo, exp_strobe, exp_busy, exp_rspv, exp_ready, en_now;
        ack_off[0] = ack0;
        ack_off[1] = ack1;
        ack_off[2] = ack2;
        acked = -1;
        for (int a = 0; a < NUM_ATT; a++) begin
            rise[a] = MIN_GAP + 1 + a * (ACK_TIMEOUT + MIN_GAP);
            if (acked < 0 && ack_off[a] >= 0) acked = a;
        end
        last_att = (acked >= 0) ? acked : NUM_ATT - 1;
        ack_t  = -1;
        done_t = -1;
        if (acked >= 0) begin
            ack_t = rise[acked] + ack_off[acked];
            if (done_d >= 0 && done_d <= DONE_TIMEOUT) begin
                done_t  = ack_t + done_d;
                resp_t  = done_t + 1;
                exp_err = err;
                exp_tmo = 1'b0;
            end else begin
                resp_t  = ack_t + 1 + DONE_TIMEOUT;
                exp_err = 3'd0;
                exp_tmo = 1'b1;
            end
        end else begin
            resp_t  = rise[NUM_ATT-1] + ACK_TIMEOUT;
            exp_err = 3'd0;
            exp_tmo = 1'b1;
        end
        t_hs = resp_t + rdelay;
        obs_rise = -1;
        obs_resp = -1;
        for (int t = 0; t <= t_hs + 1; t++) begin
            target_dataslot_ack  = (t == ack_t);
            target_dataslot_done = (t == done_t);
            target_dataslot_err  = (t == done_t) ? err : 3'($urandom);
            rsp_ready = (t == t_hs) || (t < resp_t && $urandom_range(0, 1) == 1);
            if (t == 0) begin
                req_valid = 1'b1; enable = 1'b1; req_write = wr;
                req_id = id; req_slotoffset = off; req_bridgeaddr = addr; req_length = len;
            end else if (t <= t_hs) begin
                req_valid = 1'($urandom); enable = 1'($urandom); req_write = 1'($urandom);
                req_id = 16'($urandom); req_slotoffset = $urandom;
                req_bridgeaddr = $urandom; req_length = $urandom;
            end else begin
                req_valid = 1'b0;
                enable    = 1'b1;
            end
            // Stray handshakes the sequencer must ignore: in the first gap and while responding.
            sel = int'($urandom_range(0, 3));
            if (t >= 1 && t < rise[0] && sel == 0) begin
                target_dataslot_ack  = 1'b1;
                target_dataslot_done = 1'b1;
            end
            if (t >= resp_t && t <= t_hs && sel < 2) target_dataslot_done = 1'b1;
            en_now = enable;
            @(negedge clk_74a);
            exp_strobe = 1'b0;
            for (int a = 0; a <= last_att; a++) begin
                if (t >= rise[a] && t <= ((a == acked) ? ack_t : rise[a] + ACK_TIMEOUT - 1))
                    exp_strobe = 1'b1;
            end
            exp_busy  = (t >= 1 && t <= t_hs);
            exp_rspv  = (t >= resp_t && t <= t_hs);
            exp_ready = en_now && !exp_busy;
            checks++;
            if ({target_dataslot_read, target_dataslot_write} !== {exp_strobe && !wr, exp_strobe && wr}) begin
                errors++;
                $display("FAIL strobes t=%0d: got rd/wr=%b%b required %b%b", t, target_dataslot_read,
                         target_dataslot_write, exp_strobe && !wr, exp_strobe && wr);
            end
            checks++;
            if ({busy, rsp_valid, req_ready} !== {exp_busy, exp_rspv, exp_ready}) begin
                errors++;
                $display("FAIL busy/rsp_valid/req_ready t=%0d: got %b%b%b required %b%b%b", t, busy,
                         rsp_valid, req_ready, exp_busy, exp_rspv, exp_ready);
            end
            if (t >= 1) begin
                checks++;
                if ({target_dataslot_id, target_dataslot_slotoffset, target_dataslot_bridgeaddr,
                     target_dataslot_length} !== {id, off, addr, len}) begin
                    errors++;
                    $display("FAIL params t=%0d: got id=%h off=%h addr=%h len=%h required %h %h %h %h",
                             t, target_dataslot_id, target_dataslot_slotoffset,
                             target_dataslot_bridgeaddr, target_dataslot_length, id, off, addr, len);
                end
            end
            if (exp_rspv) begin
                checks++;
                if ({rsp_err, rsp_timeout} !== {exp_err, exp_tmo}) begin
                    errors++;
                    $display("FAIL response t=%0d: got err=%0d timeout=%b required err=%0d timeout=%b",
                             t, rsp_err, rsp_timeout, exp_err, exp_tmo);
                end
            end
            if (obs_rise < 0 && (target_dataslot_read || target_dataslot_write)) obs_rise = t;
            if (obs_resp < 0 && rsp_valid) obs_resp = t;
            @(posedge clk_74a);
            #1;
        end
        target_dataslot_ack  = 1'b0;
        target_dataslot_done = 1'b0;
        rsp_ready            = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; req_valid = 1'b1; rsp_ready = 1'b1;
        target_dataslot_ack = 1'b1; target_dataslot_done = 1'b1; target_dataslot_err = 3'd5;
        repeat (3) @(posedge clk_74a);
        @(negedge clk_74a);
        checks++;
        if ({target_dataslot_read, target_dataslot_write, busy, rsp_valid, rsp_err, rsp_timeout} !== 8'd0) begin
            errors++;
            $display("FAIL reset outputs: got rd=%b wr=%b busy=%b rv=%b err=%0d to=%b required all 0",
                     target_dataslot_read, target_dataslot_write, busy, rsp_valid, rsp_err, rsp_timeout);
        end
        checks++;
        if ({target_dataslot_id, target_dataslot_slotoffset, target_dataslot_bridgeaddr,
             target_dataslot_length} !== 112'd0) begin
            errors++;
            $display("FAIL reset params: got id=%h off=%h required 0", target_dataslot_id,
                     target_dataslot_slotoffset);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset req_ready enable=1: got %b required 1", req_ready);
        end
        enable = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset req_ready enable=0: got %b required 0", req_ready);
        end
        reset = 1'b0; enable = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        target_dataslot_ack = 1'b0; target_dataslot_done = 1'b0;
        @(posedge clk_74a);
        #1;
    endtask

    task automatic test_write_basic();
        int r, p;
        run_txn(1'b1, 16'd3, 32'd0, 32'h1000_0000, 32'd512, 5, -1, -1, 20, 3'd0, 2, r, p);
        checks++;
        if (r !== MIN_GAP + 1) begin
            errors++;
            $display("FAIL write first strobe cycle: got %0d required %0d", r, MIN_GAP + 1);
        end
        checks++;
        if (p !== MIN_GAP + 1 + 5 + 20 + 1) begin
            errors++;
            $display("FAIL write response cycle: got %0d required %0d", p, MIN_GAP + 27);
        end
    endtask

    task automatic test_read_ack_done_same();
        int r, p;
        run_txn(1'b0, 16'd7, 32'h40, 32'h2000_0000, 32'd64, 0, -1, -1, 0, 3'b010, 1, r, p);
        checks++;
        if (p !== MIN_GAP + 2) begin
            errors++;
            $display("FAIL ack+done response cycle: got %0d required %0d", p, MIN_GAP + 2);
        end
    endtask

    task automatic test_ack_timeout();
        int r, p;
        run_txn(1'b1, 16'd9, 32'd8, 32'h3000_0000, 32'd16, -1, -1, -1, -1, 3'd0, 0, r, p);
        checks++;
        if (p !== MIN_GAP + 1 + MAX_RETRIES * (ACK_TIMEOUT + MIN_GAP) + ACK_TIMEOUT) begin
            errors++;
            $display("FAIL ack timeout response cycle: got %0d required %0d", p,
                     MIN_GAP + 1 + MAX_RETRIES * (ACK_TIMEOUT + MIN_GAP) + ACK_TIMEOUT);
        end
    endtask

    task automatic test_retry_success();
        int r, p;
        run_txn(1'b0, 16'd1, 32'd4, 32'h1234_5678, 32'd100, -1, 3, -1, 10, 3'd0, 3, r, p);
        checks++;
        if (p !== MIN_GAP + 1 + ACK_TIMEOUT + MIN_GAP + 3 + 10 + 1) begin
            errors++;
            $display("FAIL retry response cycle: got %0d required %0d", p,
                     MIN_GAP + 1 + ACK_TIMEOUT + MIN_GAP + 14);
        end
    endtask

    task automatic test_done_timeout();
        int r, p;
        run_txn(1'b1, 16'd2, 32'd0, 32'h0000_1000, 32'd8, 2, -1, -1, -1, 3'd6, 1, r, p);
        checks++;
        if (p !== (MIN_GAP + 1 + 2 + 1) + DONE_TIMEOUT) begin
            errors++;
            $display("FAIL done timeout response cycle: got %0d required %0d", p,
                     MIN_GAP + 4 + DONE_TIMEOUT);
        end
    endtask

    task automatic test_enable_gate();
        enable = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            req_write = 1'($urandom); req_id = 16'($urandom);
            @(negedge clk_74a);
            checks++;
            if ({req_ready, busy, target_dataslot_read, target_dataslot_write} !== 4'b0000) begin
                errors++;
                $display("FAIL enable gate cycle %0d: got ready/busy/rd/wr=%b%b%b%b required 0000", i,
                         req_ready, busy, target_dataslot_read, target_dataslot_write);
            end
            @(posedge clk_74a);
            #1;
        end
        req_valid = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        for (int t = 0; t <= MIN_GAP + 14; t++) begin
            req_valid = (t == 0);
            enable = 1'b1; req_write = 1'b1; req_id = 16'h55aa;
            req_slotoffset = 32'h10; req_bridgeaddr = 32'h8000_0000; req_length = 32'd32;
            target_dataslot_ack  = (t == MIN_GAP + 1);
            target_dataslot_done = (t >= MIN_GAP + 8 && t <= MIN_GAP + 9);
            target_dataslot_err  = 3'd4;
            reset = (t == MIN_GAP + 6);
            @(negedge clk_74a);
            if (t == MIN_GAP + 1) begin
                checks++;
                if (target_dataslot_write !== 1'b1) begin
                    errors++;
                    $display("FAIL reset-mid strobe: got %b required 1", target_dataslot_write);
                end
            end
            if (t == MIN_GAP + 5) begin
                checks++;
                if ({busy, target_dataslot_write, rsp_valid} !== 3'b100) begin
                    errors++;
                    $display("FAIL reset-mid wait_done: got busy/wr/rv=%b%b%b required 100", busy,
                             target_dataslot_write, rsp_valid);
                end
            end
            if (t >= MIN_GAP + 7) begin
                checks++;
                if ({busy, rsp_valid, target_dataslot_write, target_dataslot_id} !== 19'd0) begin
                    errors++;
                    $display("FAIL reset-mid after reset t=%0d: got busy=%b rv=%b wr=%b id=%h required 0",
                             t, busy, rsp_valid, target_dataslot_write, target_dataslot_id);
                end
            end
            @(posedge clk_74a);
            #1;
        end
        reset = 1'b0;
        target_dataslot_ack = 1'b0;
        target_dataslot_done = 1'b0;
    endtask

    task automatic test_random();
        int a[NUM_ATT];
        int dd, sel, r, p;
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < NUM_ATT; k++) begin
                if ($urandom_range(0, 2) == 0) a[k] = -1;
                else a[k] = int'($urandom_range(0, ACK_TIMEOUT - 1));
            end
            sel = int'($urandom_range(0, 3));
            if (sel == 0) dd = 0;
            else if (sel == 3) dd = -1;
            else dd = int'($urandom_range(1, DONE_TIMEOUT));
            run_txn(1'($urandom), 16'($urandom), $urandom, $urandom, $urandom, a[0], a[1], a[2],
                    dd, 3'($urandom), int'($urandom_range(0, 4)), r, p);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_id = '0;
        req_slotoffset = '0; req_bridgeaddr = '0; req_length = '0; rsp_ready = 1'b0;
        target_dataslot_ack = 1'b0; target_dataslot_done = 1'b0; target_dataslot_err = '0;
        @(posedge clk_74a);
        #1;
        test_reset();
        test_write_basic();
        test_read_ack_done_same();
        test_ack_timeout();
        test_retry_success();
        test_done_timeout();
        test_enable_gate();
        test_write_basic();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
